// File: rtl/mac_group_accumulator_if.sv
// Handshake bundle between MAC stage, group accumulator and downstream consumer.
// Latency: none, wires only.
// Backpressure: carries in_ready upstream and out_ready from downstream.
interface mac_group_accumulator_if #(
  parameter int DATA_W = 16,
  parameter int SUM_W  = 18,
  parameter int LEN_W  = 3
);
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              flush;
  logic              in_ready;
  logic [SUM_W-1:0]  out_sum;
  logic [LEN_W-1:0]  out_len;
  logic              out_valid;
  logic              out_ready;

  // Producer/consumer side: drives beats and downstream ready, observes results.
  modport master (
    output in_data, in_valid, flush, out_ready,
    input  in_ready, out_sum, out_len, out_valid
  );

  // Accumulator side.
  modport slave (
    input  in_data, in_valid, flush, out_ready,
    output in_ready, out_sum, out_len, out_valid
  );
endinterface

// File: rtl/mac_group_accumulator.sv
// Sums unsigned MAC results in groups of GROUP beats; flush closes a partial group early.
// Latency: group sum valid the cycle after its closing beat/flush is accepted.
// Backpressure: in_ready drops while the output register is full and not being drained.
module mac_group_accumulator #(
  parameter int DATA_W = 16,
  parameter int GROUP  = 4,
  parameter int SUM_W  = 18,
  parameter int LEN_W  = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  mac_group_accumulator_if.slave  bus
);
  typedef enum logic {EMPTY, FULL} out_state_t;

  out_state_t        out_state, out_state_nxt;
  logic [SUM_W-1:0]  acc, acc_nxt;
  logic [LEN_W-1:0]  cnt, cnt_nxt;
  logic [SUM_W-1:0]  sum_q, sum_nxt;
  logic [LEN_W-1:0]  len_q, len_nxt;
  logic [DATA_W-1:0] in_d;
  logic [SUM_W-1:0]  in_ext;
  logic              in_ready;
  logic              accept;
  logic              fl;
  logic              close;

  assign in_d   = bus.in_data;
  assign in_ext = SUM_W'(in_d);

  // Output register drains and refills in one cycle, so a full register with
  // out_ready high still lets a beat in.
  assign in_ready = reset & ((out_state == EMPTY) | bus.out_ready);
  assign accept   = bus.in_valid & in_ready;
  assign fl       = bus.flush & in_ready;
  // A flush on an empty accumulator with no beat closes nothing: no zero-length groups.
  assign close    = (accept & (cnt == LEN_W'(GROUP - 1))) | (fl & (accept | (cnt != '0)));

  assign bus.in_ready  = in_ready;
  assign bus.out_sum   = sum_q;
  assign bus.out_len   = len_q;
  assign bus.out_valid = (out_state == FULL);

  // Accumulator and output-data next state; the output data only changes on close,
  // which can only happen when the register is empty or being drained.
  always_comb begin
    acc_nxt = acc;
    cnt_nxt = cnt;
    sum_nxt = sum_q;
    len_nxt = len_q;
    if (close) begin
      sum_nxt = acc + (accept ? in_ext : '0);
      len_nxt = cnt + LEN_W'(accept);
      acc_nxt = '0;
      cnt_nxt = '0;
    end else if (accept) begin
      acc_nxt = acc + in_ext;
      cnt_nxt = cnt + LEN_W'(1);
    end
  end

  // Output register occupancy: filled by close, emptied by a transfer without refill.
  always_comb begin
    out_state_nxt = out_state;
    if (close) begin
      out_state_nxt = FULL;
    end else if ((out_state == FULL) && bus.out_ready) begin
      out_state_nxt = EMPTY;
    end
  end

  // State registers; reset discards any partial group and pending output.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_state <= EMPTY;
      acc       <= '0;
      cnt       <= '0;
      sum_q     <= '0;
      len_q     <= '0;
    end else begin
      out_state <= out_state_nxt;
      acc       <= acc_nxt;
      cnt       <= cnt_nxt;
      sum_q     <= sum_nxt;
      len_q     <= len_nxt;
    end
  end
endmodule

// File: tb/tb_mac_group_accumulator.sv
// Directed bench for mac_group_accumulator with hand-computed group sums.
// Latency: checks registered outputs 1 time unit after each rising edge.
// Backpressure: exercises out_ready stalls and flush gating while in_ready is low.
module tb_mac_group_accumulator;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mac_group_accumulator_if #(.DATA_W(16), .SUM_W(18), .LEN_W(3)) bus ();

  mac_group_accumulator #(.DATA_W(16), .GROUP(4), .SUM_W(18), .LEN_W(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    bus.in_data  = '0;
  endtask

  // Present one beat for one cycle; the accumulator must be ready.
  task automatic beat(input logic [15:0] d, input logic f, input string tag);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.flush    = f;
    #1;
    check({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    cyc();
    idle();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    bus.out_ready = 1'b1;
    idle();

    // Reset state
    cyc();
    cyc();
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_sum",   32'(bus.out_sum),   32'd0);
    check("rst_out_len",   32'(bus.out_len),   32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd0);
    reset = 1'b1;
    #1;
    check("rel_in_ready", 32'(bus.in_ready), 32'd1);

    // 1: beats 1..4 -> 10, len 4, single-cycle pulse
    for (int i = 1; i <= 4; i++) begin
      beat(16'(i), 1'b0, "t1");
      if (i < 4) check("t1_no_early_valid", 32'(bus.out_valid), 32'd0);
    end
    check("t1_valid", 32'(bus.out_valid), 32'd1);
    check("t1_sum",   32'(bus.out_sum),   32'd10);
    check("t1_len",   32'(bus.out_len),   32'd4);
    cyc();
    check("t1_pulse_end", 32'(bus.out_valid), 32'd0);

    // 2: 8 x 0xFFFF continuous -> two 0x3FFFC
    for (int i = 0; i < 8; i++) begin
      beat(16'hFFFF, 1'b0, "t2");
      if (i == 3 || i == 7) begin
        check("t2_valid", 32'(bus.out_valid), 32'd1);
        check("t2_sum",   32'(bus.out_sum),   32'h3FFFC);
        check("t2_len",   32'(bus.out_len),   32'd4);
      end
      if (i == 4) check("t2_drained", 32'(bus.out_valid), 32'd0);
    end
    cyc();
    check("t2_end", 32'(bus.out_valid), 32'd0);

    // 3: backpressure holds the result and stalls input
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) beat(16'hFFFF, 1'b0, "t3a");
    bus.in_valid = 1'b1;
    bus.in_data  = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_stall_in_ready", 32'(bus.in_ready),  32'd0);
      check("t3_stall_valid",    32'(bus.out_valid), 32'd1);
      check("t3_stall_sum",      32'(bus.out_sum),   32'h3FFFC);
      cyc();
    end
    // Held beat is taken as soon as the register drains; three more complete the group.
    bus.out_ready = 1'b1;
    #1;
    check("t3_resume_in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    idle();
    check("t3_drained", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 3; i++) beat(16'hFFFF, 1'b0, "t3b");
    check("t3_valid2", 32'(bus.out_valid), 32'd1);
    check("t3_sum2",   32'(bus.out_sum),   32'h3FFFC);
    check("t3_len2",   32'(bus.out_len),   32'd4);
    cyc();

    // 4: partial groups closed by flush
    beat(16'd5, 1'b0, "t4");
    beat(16'd7, 1'b0, "t4");
    check("t4_no_valid", 32'(bus.out_valid), 32'd0);
    bus.flush = 1'b1;
    cyc();
    idle();
    check("t4_valid", 32'(bus.out_valid), 32'd1);
    check("t4_sum",   32'(bus.out_sum),   32'd12);
    check("t4_len",   32'(bus.out_len),   32'd2);
    cyc();
    check("t4_pulse_end", 32'(bus.out_valid), 32'd0);
    beat(16'd9, 1'b1, "t4b");
    check("t4b_valid", 32'(bus.out_valid), 32'd1);
    check("t4b_sum",   32'(bus.out_sum),   32'd9);
    check("t4b_len",   32'(bus.out_len),   32'd1);
    cyc();

    // 5: empty flush is a no-op; flush/beat ignored while stalled
    bus.flush = 1'b1;
    cyc();
    idle();
    check("t5_empty_flush", 32'(bus.out_valid), 32'd0);
    cyc();
    check("t5_empty_flush2", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    beat(16'd3, 1'b1, "t5a");
    check("t5_full_sum", 32'(bus.out_sum), 32'd3);
    bus.in_valid = 1'b1;
    bus.in_data  = 16'd6;
    bus.flush    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("t5_stall_in_ready", 32'(bus.in_ready), 32'd0);
      cyc();
      check("t5_hold_sum", 32'(bus.out_sum), 32'd3);
      check("t5_hold_len", 32'(bus.out_len), 32'd1);
    end
    idle();
    bus.out_ready = 1'b1;
    cyc();
    check("t5_drain", 32'(bus.out_valid), 32'd0);
    for (int i = 0; i < 4; i++) beat(16'd2, 1'b0, "t5b");
    check("t5_sum_clean", 32'(bus.out_sum), 32'd8);
    check("t5_len_clean", 32'(bus.out_len), 32'd4);
    cyc();

    // 6: reset mid-group discards partial sum
    beat(16'd100, 1'b0, "t6a");
    beat(16'd200, 1'b0, "t6a");
    reset = 1'b0;
    #1;
    check("t6_rst_in_ready", 32'(bus.in_ready), 32'd0);
    cyc();
    check("t6_rst_valid",    32'(bus.out_valid), 32'd0);
    check("t6_rst_in_ready2", 32'(bus.in_ready), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) beat(16'd1, 1'b0, "t6b");
    check("t6_valid", 32'(bus.out_valid), 32'd1);
    check("t6_sum",   32'(bus.out_sum),   32'd4);
    check("t6_len",   32'(bus.out_len),   32'd4);
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
